ram_burst_master: RTL and testbench
===================================

// Module: ram_burst_master
// PURPOSE
//   Initiator for the single-port RAM interface: addr/we/D driven, Q read combinationally.
//   Accepts burst commands (write or read, base address, length).
//   Write bursts take a valid/ready input stream and write it to the RAM.
//   Read bursts stream RAM contents out on a valid/ready output.
//   Sits between stream producers/consumers and one RAM instance.
// PARAMETERS
//   Width        8  data word width; must match the RAM Width
//   AddressSize  4  RAM address bits; depth = 2**AddressSize
// PORTS
//   clk        in   1              clock, rising edge
//   rst        in   1              asynchronous, active-low reset
//   cmd_valid  in   1              command offered
//   cmd_ready  out  1              command accepted on cmd_valid&cmd_ready at posedge
//   cmd_write  in   1              1 = write burst, 0 = read burst
//   cmd_addr   in   AddressSize    burst base address
//   cmd_len    in   AddressSize+1  words in burst, 0..2**AddressSize
//   wr_valid   in   1              write data offered
//   wr_ready   out  1              write data accepted
//   wr_data    in   Width          write data word
//   rd_valid   out  1              read data offered
//   rd_ready   in   1              read data accepted
//   rd_data    out  Width          read data word
//   mem_we     out  1              RAM write enable
//   mem_addr   out  AddressSize    RAM address
//   mem_D      out  Width          RAM write data
//   mem_Q      in   Width          RAM read data, combinational from mem_addr
//   busy       out  1              state != IDLE
//   done       out  1              one-cycle pulse when a burst completes
// BEHAVIOUR
// - States: IDLE, WRITE, READ, DONE. While rst=0 (async): state=IDLE, addr counter=0,
//   remaining=0, rd_valid=0, rd_data=0.
// - Outputs while reset is held: cmd_ready=1, wr_ready=0, mem_we=0, mem_addr=0, mem_D=0,
//   busy=0, done=0.
// - cmd_ready = (state==IDLE).
// - Command accept at edge N latches addr=cmd_addr and remaining=cmd_len.
//   Next state: DONE if cmd_len==0; else WRITE if cmd_write; else READ.
// - WRITE: wr_ready=1. mem_we=wr_valid (combinational). mem_D=wr_data. mem_addr=addr.
//   The RAM stores the word on the same edge as the handshake.
//   On each handshake: addr+=1 mod 2**AddressSize, remaining-=1.
//   The last handshake (remaining==1) moves the block to DONE.
//   Sustains 1 word/cycle.
// - Outside WRITE: wr_ready=0, mem_we=0, mem_D=0.
//   Write data presented in IDLE is not consumed.
// - READ: mem_addr=addr.
//   At each edge where remaining>0 and (!rd_valid | rd_ready):
//   rd_data<=mem_Q, rd_valid<=1, addr+=1 (wraps), remaining-=1.
//   First rd_valid appears the cycle after entry to READ.
//   With rd_ready held high: 1 word/cycle.
// - READ backpressure: while rd_valid & !rd_ready, rd_data and addr hold.
//   No word is dropped or duplicated.
// - READ completion: at the edge with rd_valid&rd_ready and remaining==0,
//   rd_valid<=0 and the state moves to DONE. rd_data keeps its last value.
// - DONE: done=1, busy=1, cmd_ready=0 for exactly one cycle, then IDLE.
// - Address wrap: 2**AddressSize-1 -> 0. cmd_len=2**AddressSize covers the whole RAM once.
// - Reset mid-burst aborts immediately: outputs take reset values asynchronously.
//   RAM words already written stay written. No done pulse.
// TESTING
//  1 Write burst, addr=2 len=3, data A1,A2,A3, wr_valid held high ->
//    mem_we high 3 cycles at addrs 2,3,4; done 1 cycle after; then IDLE.
//  2 Read burst, addr=2 len=3, rd_ready=1, RAM from test 1 ->
//    rd_data A1,A2,A3 on consecutive cycles from 1 cycle after entry; done follows.
//  3 Read addr=0 len=4, rd_ready low 3 cycles after word 1 ->
//    rd_data/rd_valid stable during stall; sequence exactly mem[0..3].
//  4 Write addr=14 len=4 ->
//    mem_we at addrs 14,15,0,1; read back addr=14 len=4 matches.
//  5 cmd_len=0 ->
//    no mem_we, no rd_valid; DONE the cycle after accept; cmd_ready again the cycle after.
//  6 rst low after 2 read words ->
//    rd_valid=0, busy=0, cmd_ready=1 without clock edge; next command runs normally.

Source files
------------

// File: rtl/ram_burst_master.sv
// ============================================================================
// Module   : ram_burst_master
// Brief    : Burst initiator for a single-port RAM. It moves a valid/ready
//            write stream into the RAM and streams RAM words out on a
//            valid/ready read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_burst_master #(
    parameter int Width       = 8,
    parameter int AddressSize = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [AddressSize-1:0] cmd_addr,
    input  logic [AddressSize:0]   cmd_len,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [Width-1:0]       wr_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [Width-1:0]       rd_data,
    output logic                   mem_we,
    output logic [AddressSize-1:0] mem_addr,
    output logic [Width-1:0]       mem_D,
    input  logic [Width-1:0]       mem_Q,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_WRITE = 2'd1;
    localparam logic [1:0] C_READ  = 2'd2;
    localparam logic [1:0] C_DONE  = 2'd3;

    localparam logic [AddressSize:0] C_LEN_ZERO = '0;
    localparam logic [AddressSize:0] C_LEN_ONE  = (AddressSize+1)'(1);

    logic [1:0]             state_q,    state_d;
    logic [AddressSize-1:0] addr_q,     addr_d;
    logic [AddressSize:0]   rem_q,      rem_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [Width-1:0]       rd_data_q,  rd_data_d;

    logic                   w_rd_load;

    // Output register slot is free when empty or being drained this edge.
    assign w_rd_load = (rem_q != C_LEN_ZERO) && (!rd_valid_q || rd_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= C_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        case (state_q)
            C_IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    if (cmd_len == C_LEN_ZERO) begin
                        state_d = C_DONE;
                    end else if (cmd_write) begin
                        state_d = C_WRITE;
                    end else begin
                        state_d = C_READ;
                    end
                end
            end
            C_WRITE: begin
                if (wr_valid) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == C_LEN_ONE) begin
                        state_d = C_DONE;
                    end
                end
            end
            C_READ: begin
                if (w_rd_load) begin
                    rd_data_d  = mem_Q;
                    rd_valid_d = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    rem_d      = rem_q - 1'b1;
                end else if (rd_valid_q && rd_ready) begin
                    rd_valid_d = 1'b0;
                    state_d    = C_DONE;
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == C_IDLE);
        wr_ready  = (state_q == C_WRITE);
        mem_we    = (state_q == C_WRITE) && wr_valid;
        mem_D     = (state_q == C_WRITE) ? wr_data : '0;
        mem_addr  = addr_q;
        rd_valid  = rd_valid_q;
        rd_data   = rd_data_q;
        busy      = (state_q != C_IDLE);
        done      = (state_q == C_DONE);
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_master.sv
// ============================================================================
// Module   : tb_ram_burst_master
// Brief    : Directed self-checking bench for ram_burst_master with a
//            behavioural single-port RAM attached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_burst_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_addr;
    logic [4:0] cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [7:0] rd_data;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_D, mem_Q;
    logic       busy, done;

    int total = 0;
    int bad   = 0;

    logic [7:0] wdat [16];
    logic [7:0] exp_q [16];

    // Untouched RAM words read back as 8'h50 + address.
    logic [7:0]  ram [16];
    logic [15:0] wmask = 16'h0000;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]   <= mem_D;
            wmask[mem_addr] <= 1'b1;
        end
    end

    function automatic logic [7:0] ram_rd(input logic [3:0] a);
        return wmask[a] ? ram[a] : (8'h50 + {4'h0, a});
    endfunction

    assign mem_Q = ram_rd(mem_addr);

    ram_burst_master #(.Width(8), .AddressSize(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_D     (mem_D),
        .mem_Q     (mem_Q),
        .busy      (busy),
        .done      (done)
    );

    task automatic issue_cmd(input logic w, input logic [3:0] a, input logic [4:0] l);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        #1;
        total++;
        if (cmd_ready !== 1'b1 || mem_we !== 1'b0 || wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_accept: cmd_ready=%b mem_we=%b wr_ready=%b want 1 0 0",
                     cmd_ready, mem_we, wr_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] a, input logic [4:0] l);
        logic [3:0] ea;
        wr_valid = 1'b1;
        wr_data  = wdat[0];
        issue_cmd(1'b1, a, l);
        for (int i = 0; i < int'(l); i++) begin
            ea = a + 4'(i);
            @(negedge clk);
            wr_data = wdat[i];
            #1;
            total++;
            if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ea || mem_D !== wdat[i]) begin
                bad++;
                $display("FAIL write_beat%0d: ready=%b we=%b addr=%h D=%h want 1 1 %h %h",
                         i, wr_ready, mem_we, mem_addr, mem_D, ea, wdat[i]);
            end
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL write_done: done=%b busy=%b cmd_ready=%b we=%b want 1 1 0 0",
                     done, busy, cmd_ready, mem_we);
        end
        @(negedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL write_idle: done=%b busy=%b cmd_ready=%b want 0 0 1", done, busy, cmd_ready);
        end
        for (int i = 0; i < int'(l); i++) begin
            ea = a + 4'(i);
            total++;
            if (ram_rd(ea) !== wdat[i]) begin
                bad++;
                $display("FAIL ram_content[%h]: got %h want %h", ea, ram_rd(ea), wdat[i]);
            end
        end
    endtask

    task automatic read_burst(input logic [3:0] a, input logic [4:0] l, input logic stall);
        int k   = 0;
        int sn  = 0;
        int cyc = 0;
        logic fin = 1'b0;
        rd_ready = 1'b1;
        issue_cmd(1'b0, a, l);
        @(negedge clk);
        #1;
        total++;
        if (rd_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL read_entry: rd_valid=%b busy=%b want 0 1", rd_valid, busy);
        end
        while (!fin && cyc < 40) begin
            @(negedge clk);
            cyc++;
            rd_ready = !(stall && k == 1 && sn < 3);
            if (!rd_ready) sn++;
            #1;
            if (!rd_ready) begin
                total++;
                if (rd_valid !== 1'b1 || rd_data !== exp_q[1] || mem_addr !== a + 4'd2) begin
                    bad++;
                    $display("FAIL read_stall: valid=%b data=%h addr=%h want 1 %h %h",
                             rd_valid, rd_data, mem_addr, exp_q[1], a + 4'd2);
                end
            end
            if (rd_valid && rd_ready) begin
                total++;
                if (k >= int'(l) || rd_data !== exp_q[k]) begin
                    bad++;
                    $display("FAIL read_word%0d: got %h want %h", k, rd_data, exp_q[k[3:0]]);
                end
                k++;
            end
            if (done) fin = 1'b1;
        end
        total++;
        if (fin !== 1'b1 || k != int'(l) || rd_valid !== 1'b0 || rd_data !== exp_q[l[3:0] - 4'd1]) begin
            bad++;
            $display("FAIL read_end: done_seen=%b words=%0d rd_valid=%b rd_data=%h want 1 %0d 0 %h",
                     fin, k, rd_valid, rd_data, l, exp_q[l[3:0] - 4'd1]);
        end
        if (!stall) begin
            total++;
            if (cyc != int'(l) + 1) begin
                bad++;
                $display("FAIL read_rate: cycles=%0d want %0d", cyc, int'(l) + 1);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL read_idle: cmd_ready=%b done=%b want 1 0", cmd_ready, done);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (cmd_ready !== 1'b1 || wr_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 4'h0 ||
            mem_D !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: cr=%b wr=%b we=%b a=%h D=%h busy=%b done=%b rv=%b rd=%h",
                     cmd_ready, wr_ready, mem_we, mem_addr, mem_D, busy, done, rd_valid, rd_data);
        end
        @(negedge clk);
        rst      = 1'b1;
        wr_valid = 1'b0;
    endtask

    task automatic test_write_basic();
        wdat[0] = 8'hA1; wdat[1] = 8'hA2; wdat[2] = 8'hA3;
        write_burst(4'd2, 5'd3);
    endtask

    task automatic test_read_basic();
        exp_q[0] = 8'hA1; exp_q[1] = 8'hA2; exp_q[2] = 8'hA3;
        read_burst(4'd2, 5'd3, 1'b0);
    endtask

    task automatic test_read_stall();
        exp_q[0] = 8'h50; exp_q[1] = 8'h51; exp_q[2] = 8'hA1; exp_q[3] = 8'hA2;
        read_burst(4'd0, 5'd4, 1'b1);
    endtask

    task automatic test_wrap();
        wdat[0] = 8'hC0; wdat[1] = 8'hC1; wdat[2] = 8'hC2; wdat[3] = 8'hC3;
        write_burst(4'd14, 5'd4);
        exp_q[0] = 8'hC0; exp_q[1] = 8'hC1; exp_q[2] = 8'hC2; exp_q[3] = 8'hC3;
        read_burst(4'd14, 5'd4, 1'b0);
    endtask

    task automatic test_zero_len();
        for (int w = 0; w < 2; w++) begin
            wr_valid = (w == 1);
            rd_ready = 1'b1;
            issue_cmd(w[0], 4'd7, 5'd0);
            @(negedge clk);
            #1;
            total++;
            if (done !== 1'b1 || cmd_ready !== 1'b0 || mem_we !== 1'b0 || rd_valid !== 1'b0) begin
                bad++;
                $display("FAIL zero_len_done%0d: done=%b cr=%b we=%b rv=%b want 1 0 0 0",
                         w, done, cmd_ready, mem_we, rd_valid);
            end
            @(negedge clk);
            #1;
            total++;
            if (done !== 1'b0 || cmd_ready !== 1'b1 || mem_we !== 1'b0) begin
                bad++;
                $display("FAIL zero_len_idle%0d: done=%b cr=%b we=%b want 0 1 0", w, done, cmd_ready, mem_we);
            end
            wr_valid = 1'b0;
        end
    endtask

    task automatic test_reset_abort();
        rd_ready = 1'b1;
        issue_cmd(1'b0, 4'd0, 5'd8);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 ||
            mem_addr !== 4'h0 || rd_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_abort: rv=%b busy=%b cr=%b done=%b a=%h rd=%h want 0 0 1 0 0 00",
                     rd_valid, busy, cmd_ready, done, mem_addr, rd_data);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q[0] = 8'h55; exp_q[1] = 8'h56;
        read_burst(4'd5, 5'd2, 1'b0);
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'h0;
        cmd_len   = 5'h0;
        wr_valid  = 1'b1;
        wr_data   = 8'hFF;
        rd_ready  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wdat[i]  = 8'h00;
            exp_q[i] = 8'h00;
        end
        test_reset();
        test_write_basic();
        test_read_basic();
        test_read_stall();
        test_wrap();
        test_zero_len();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
